// File: rtl/shift_ctrl.sv
`default_nettype none
// ============================================================================
// shift_ctrl : command sequencer for an external serial right-shifter.
//   Optional feature macro: SHIFT_CTRL_ROR_EN (enables rotate-right, op 11).
//   Revision: 1.0
// ============================================================================
module shift_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_op,
   input  logic [WIDTH-1:0]         cmd_data,
   input  logic [$clog2(WIDTH)-1:0] cmd_amt,
   output logic                     sh_en,
   output logic                     sh_din,
   output logic                     sh_lr,
   input  logic [WIDTH-1:0]         sh_dout,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [WIDTH-1:0]         rsp_data,
   output logic                     rsp_err,
   output logic                     busy
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_SRA  = 2'b01;
   localparam logic [1:0] OP_SRL  = 2'b10;
   localparam logic [1:0] OP_ROR  = 2'b11;
`ifdef SHIFT_CTRL_ROR_EN
   localparam bit ROR_EN = 1'b1;
`else
   localparam bit ROR_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_err_q, rsp_err_d;
   logic [CW-1:0]    cmd_cnt;
   logic             cmd_err;

   // Count is WIDTH for LOAD; a disabled rotate becomes a zero-shift error.
   always_comb begin
      cmd_cnt = {1'b0, cmd_amt};
      cmd_err = 1'b0;
      if (cmd_op == OP_LOAD) begin
         cmd_cnt = CW'(WIDTH);
      end else if (cmd_op == OP_ROR && !ROR_EN) begin
         cmd_cnt = '0;
         cmd_err = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      data_d      = data_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               op_d    = cmd_op;
               data_d  = cmd_data;
               cnt_d   = cmd_cnt;
               err_d   = cmd_err;
               state_d = (cmd_cnt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            if (op_q == OP_LOAD) data_d = data_q >> 1;
            if (cnt_q <= CW'(1)) state_d = DONE;
         end
         DONE: begin
            // First DONE cycle lets the last shift settle before capture.
            if (!rsp_valid_q) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = sh_dout;
               rsp_err_d   = err_q;
            end else if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= IDLE;
         op_q        <= OP_LOAD;
         data_q      <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         data_q      <= data_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   always_comb begin
      sh_din = 1'b0;
      if (state_q == SHIFT) begin
         case (op_q)
            OP_LOAD: sh_din = data_q[0];
            OP_SRA:  sh_din = sh_dout[WIDTH-1];
            OP_SRL:  sh_din = 1'b0;
            OP_ROR:  sh_din = sh_dout[0];
            default: sh_din = 1'b0;
         endcase
      end
   end

   assign cmd_ready = (state_q == IDLE) && !Rst;
   assign sh_en     = (state_q == SHIFT);
   assign sh_lr     = !((state_q != IDLE) && (op_q == OP_SRA));
   assign busy      = (state_q != IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_ctrl.sv
`default_nettype none
// ============================================================================
// tb_shift_ctrl : scoreboard bench for shift_ctrl with a behavioural shifter.
//   Revision: 1.0
// ============================================================================
module tb_shift_ctrl;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [2:0]       cmd_amt;
   logic             sh_en, sh_din, sh_lr;
   logic [WIDTH-1:0] sh_dout;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_err;
   logic             busy;

   logic             preload_en = 1'b0;
   logic [WIDTH-1:0] preload_val = '0;
   logic [WIDTH-1:0] sh_reg = '0;

   int   checks = 0;
   int   errors = 0;
   int   en_cnt = 0;
   int   lr_bad = 0;
   logic exp_lr = 1'b1;
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

   shift_ctrl #(.WIDTH(WIDTH)) dut (
      .Clk(clk), .Rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .cmd_amt(cmd_amt),
      .sh_en(sh_en), .sh_din(sh_din), .sh_lr(sh_lr), .sh_dout(sh_dout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .busy(busy)
   );

   // External shifter: arithmetic mode replicates its own MSB.
   always @(posedge clk) begin
      if (preload_en) sh_reg <= preload_val;
      else if (sh_en) sh_reg <= sh_lr ? {sh_din, sh_reg[WIDTH-1:1]}
                                      : {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};
   end
   assign sh_dout = sh_reg;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sh_en) begin
         en_cnt++;
         if (sh_lr !== exp_lr) lr_bad++;
      end
   end

   // Monitor: one pop per response handshake.
   always @(negedge clk) begin
      logic [8:0] e;
      if (!rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_data", {24'd0, rsp_data}, {24'd0, e[7:0]});
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e[8]});
         end
      end
   end

   task automatic run_cmd(input logic [1:0] op, input logic [7:0] data, input logic [2:0] amt,
                          input logic [7:0] init, input logic [7:0] exp_d, input logic exp_e,
                          input int exp_n, input logic lr, input int hold);
      int n;
      int en0;
      int lrb0;
      logic [7:0] d;
      @(negedge clk);
      preload_en = 1'b1; preload_val = init;
      @(negedge clk);
      preload_en = 1'b0;
      exp_q.push_back({exp_e, exp_d});
      exp_lr = lr;
      en0 = en_cnt; lrb0 = lr_bad;
      cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_amt = amt;
      rsp_ready = (hold == 0);
      n = 0;
      while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
      chk("cmd_ready", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 100);
      chk("latency", n, exp_n + 2);
      if (hold > 0) begin
         d = rsp_data;
         cmd_valid = 1'b1;
         repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_data", {24'd0, rsp_data}, {24'd0, d});
            chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
         end
         @(posedge clk); #1;
         cmd_valid = 1'b0;
         rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk("idle_after_rsp", {31'd0, busy}, 32'd0);
      chk("shift_count", en_cnt - en0, exp_n);
      chk("sh_lr_mode", lr_bad - lrb0, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int en0;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0; cmd_amt = '0; rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_sh_en", {31'd0, sh_en}, 32'd0);
      chk("rst_sh_din", {31'd0, sh_din}, 32'd0);
      chk("rst_sh_lr", {31'd0, sh_lr}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

      //      op     data   amt   init   exp    err   n  lr    hold
      run_cmd(2'b00, 8'hA5, 3'd0, 8'h00, 8'hA5, 1'b0, 8, 1'b1, 0);
      run_cmd(2'b01, 8'h00, 3'd3, 8'h90, 8'hF2, 1'b0, 3, 1'b0, 0);
      run_cmd(2'b10, 8'h00, 3'd3, 8'h90, 8'h12, 1'b0, 3, 1'b1, 0);
`ifdef SHIFT_CTRL_ROR_EN
      run_cmd(2'b11, 8'h00, 3'd1, 8'h81, 8'hC0, 1'b0, 1, 1'b1, 0);
`else
      run_cmd(2'b11, 8'h00, 3'd1, 8'h81, 8'h81, 1'b1, 0, 1'b1, 0);
`endif
      run_cmd(2'b10, 8'h00, 3'd0, 8'h3C, 8'h3C, 1'b0, 0, 1'b1, 5);
      run_cmd(2'b01, 8'h00, 3'd7, 8'h80, 8'hFF, 1'b0, 7, 1'b0, 0);
      run_cmd(2'b00, 8'h3C, 3'd5, 8'hFF, 8'h3C, 1'b0, 8, 1'b1, 0);

      // Reset during the fourth LOAD shift: no response may appear.
      @(negedge clk);
      exp_lr = 1'b1;
      en0 = en_cnt;
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'hA5; cmd_amt = '0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
      chk("midrst_sh_en", {31'd0, sh_en}, 32'd0);
      chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_shifts", en_cnt - en0, 32'd4);
      rst = 1'b0;
      #1;
      chk("midrst_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
      repeat (5) @(negedge clk);
      chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);

      run_cmd(2'b00, 8'h5A, 3'd0, 8'h00, 8'h5A, 1'b0, 8, 1'b1, 0);

      @(negedge clk);
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/shift_ctrl.md
SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of the controlled shifter datapath; supported values are powers of two from 4 to 32.
REQ-002 SHALL have port Clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port Rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-005 SHALL have port cmd_ready, output, 1 bit: the controller accepts a command.
REQ-006 SHALL have port cmd_op, input, 2 bits: 00 LOAD, 01 SRA (arithmetic), 10 SRL (logical), 11 ROR (rotate right).
REQ-007 SHALL have port cmd_data, input, WIDTH bits: the byte to be serialised for LOAD.
REQ-008 SHALL have port cmd_amt, input, log2(WIDTH) bits: shift count for SRA/SRL/ROR.
REQ-009 SHALL have port sh_en, output, 1 bit: shifter enable; the shifter shifts right one position on each edge where sh_en=1 and holds otherwise.
REQ-010 SHALL have port sh_din, output, 1 bit: serial bit entering the shifter MSB.
REQ-011 SHALL have port sh_lr, output, 1 bit: shifter mode, 0 arithmetic, 1 logical.
REQ-012 SHALL have port sh_dout, input, WIDTH bits: current shifter contents.
REQ-013 SHALL have port rsp_valid, output, 1 bit: a result is available.
REQ-014 SHALL have port rsp_ready, input, 1 bit: the consumer accepts the result.
REQ-015 SHALL have port rsp_data, output, WIDTH bits: the shifter contents captured when the command completes.
REQ-016 SHALL have port rsp_err, output, 1 bit: the command was illegal.
REQ-017 SHALL have port busy, output, 1 bit: the state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, SHIFT, DONE.
REQ-019 SHALL assert cmd_ready only in IDLE; a command is accepted on an edge where cmd_valid=1 and cmd_ready=1.
REQ-020 SHALL latch op, data and count at acceptance; the count is WIDTH for LOAD and cmd_amt otherwise.
REQ-021 SHALL move IDLE->SHIFT when the latched count is nonzero, and IDLE->DONE when it is zero; for cmd_amt=0 the contents are returned unchanged.
REQ-022 SHALL assert sh_en during SHIFT only, for exactly count consecutive cycles, then move SHIFT->DONE.
REQ-023 SHALL drive sh_din by op: LOAD gives the latched data bits LSB first, one per shift; SRA gives sh_dout[WIDTH-1]; SRL gives 0; ROR gives sh_dout[0].
REQ-024 SHALL drive sh_lr=0 for SRA and sh_lr=1 otherwise, held constant for the whole command.
REQ-025 SHALL, on entering DONE, capture sh_dout into rsp_data and assert rsp_valid.
REQ-026 SHALL hold rsp_valid, rsp_data and rsp_err stable until rsp_ready=1, then return to IDLE on that edge.
REQ-027 SHALL give, for a command accepted at edge T with count N, rsp_valid high in the cycle following edge T+N+1, and for N=0 in the cycle following edge T+1.
REQ-028 SHALL keep sh_en=0 in IDLE and DONE; cmd_valid while busy is ignored, and a new command may be accepted on the edge after the response handshake.
REQ-029 SHALL decrement the count once per shift with no wrap-around; the count never underflows.

Reset
REQ-030 SHALL, on an edge with Rst=1, force IDLE from any state, including mid-SHIFT or DONE, and discard the pending command.
REQ-031 SHALL hold during and after reset: cmd_ready=0 while Rst=1, and after reset sh_en=0, sh_din=0, sh_lr=1, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0.
REQ-032 SHALL NOT clear the external shifter contents on reset; only sh_en is forced low.

Configuration
REQ-033 SHALL support macro SHIFT_CTRL_ROR_EN; when defined, op 11 performs a rotate right per REQ-023 with rsp_err=0.
REQ-034 SHALL, without SHIFT_CTRL_ROR_EN, accept op 11, perform zero shifts (sh_en stays 0), go directly to DONE with rsp_data=sh_dout and rsp_err=1.

Verification
REQ-035 SHALL cover LOAD: cmd_data=0xA5, shifter at 0x00 -> sh_en high 8 cycles, rsp_data=0xA5, rsp_err=0.
REQ-036 SHALL cover SRA: shifter 0x90, amt=3 -> 3 shifts with sh_lr=0, rsp_data=0xF2.
REQ-037 SHALL cover SRL then ROR: shifter 0x90, SRL amt=3 -> rsp_data=0x12; shifter 0x81, ROR amt=1 -> 0xC0 with the macro, and rsp_data=0x81 with rsp_err=1 without it.
REQ-038 SHALL cover amt=0 plus backpressure: SRL amt=0 with rsp_ready held 0 for 5 cycles -> sh_en never high, rsp_valid and rsp_data stable, cmd_ready=0 throughout.
REQ-039 SHALL cover reset mid-operation: Rst pulsed during the 4th LOAD shift -> next cycle IDLE, sh_en=0, rsp_valid=0, cmd_ready=1 after Rst drops.
